// File: rtl/score_keeper_if.sv
// score_keeper_if
//   Groups the lane-side inputs and the score/display outputs of one
//   score_keeper instance.
//   master : drives active, pt_bus, miss; observes the score outputs.
//   slave  : the score_keeper itself.
//   Signals:
//     active     game running (score and combo frozen when low)
//     pt_bus     NLIGHT concatenated signed 4-bit point codes
//     miss       one-cycle strobe, lit light left the column unpressed
//     score_bin  clamped score, unsigned binary
//     score_bcd  {hundreds, tens, ones} of the last completed conversion
//     combo      consecutive-hit count (saturates at 99)
//     max_combo  largest combo since reset
//     hit        registered pulse after a cycle with a positive sum
//     bcd_busy   binary-to-BCD conversion in progress
interface score_keeper_if #(
   parameter int NLIGHT = 5
);
   logic                  active;
   logic [4*NLIGHT-1:0]   pt_bus;
   logic                  miss;
   logic [9:0]            score_bin;
   logic [11:0]           score_bcd;
   logic [6:0]            combo;
   logic [6:0]            max_combo;
   logic                  hit;
   logic                  bcd_busy;

   modport master (
      output active, pt_bus, miss,
      input  score_bin, score_bcd, combo, max_combo, hit, bcd_busy
   );

   modport slave (
      input  active, pt_bus, miss,
      output score_bin, score_bcd, combo, max_combo, hit, bcd_busy
   );
endinterface

// File: rtl/score_keeper.sv
// score_keeper
//   Sums the signed point codes of one lane's light column, keeps a clamped
//   score, a hit combo and a best combo, and converts the score to three BCD
//   digits with a sequential double-dabble engine (IDLE -> SHIFT x10 -> DONE).
//   Ports:
//     clk    system clock, all state changes on its rising edge
//     rst_n  synchronous active-low reset
//     sk     score_keeper_if slave modport (lane inputs, score outputs)
module score_keeper #(
   parameter int NLIGHT      = 5,
   parameter int COMBO_BONUS = 10,
   parameter int SCORE_MAX   = 999
) (
   input  logic           clk,
   input  logic           rst_n,
   score_keeper_if.slave  sk
);

   localparam logic signed [11:0] SCORE_MAX_S = 12'(SCORE_MAX);
   localparam logic [9:0]         SCORE_MAX_B = 10'(SCORE_MAX);
   localparam logic [6:0]         BONUS_LEN   = 7'(COMBO_BONUS);
   localparam logic [6:0]         COMBO_CAP   = 7'd99;

   // ---------------- point sum ----------------
   logic signed [6:0] code_ext [NLIGHT];
   logic signed [6:0] sum;

   genvar gi;
   generate
      for (gi = 0; gi < NLIGHT; gi++) begin : g_ext
         assign code_ext[gi] = {{3{sk.pt_bus[4*gi+3]}}, sk.pt_bus[4*gi +: 4]};
      end
   endgenerate

   always_comb begin
      sum = '0;
      for (int i = 0; i < NLIGHT; i++) begin
         sum = sum + code_ext[i];
      end
   end

   // ---------------- score / combo ----------------
   logic [9:0]         score_reg, score_next;
   logic [6:0]         combo_reg, combo_next;
   logic [6:0]         max_reg, max_next;
   logic               hit_reg;
   logic               sum_pos, sum_neg, bonus;
   logic signed [11:0] sum_ext, delta, total;

   assign sum_pos = (sum > 7'sd0);
   assign sum_neg = sum[6];
   // A miss in the same cycle as a hit breaks the streak, so no doubling.
   assign bonus   = sum_pos && (combo_reg >= BONUS_LEN) && !sk.miss;
   assign sum_ext = {{5{sum[6]}}, sum};
   assign delta   = bonus ? (sum_ext + sum_ext) : sum_ext;
   assign total   = $signed({2'b00, score_reg}) + delta;

   always_comb begin
      score_next = total[9:0];
      if (total < 12'sd0) begin
         score_next = '0;
      end else if (total > SCORE_MAX_S) begin
         score_next = SCORE_MAX_B;
      end

      combo_next = combo_reg;
      if (sk.miss || sum_neg) begin
         combo_next = '0;
      end else if (sum_pos) begin
         combo_next = (combo_reg >= COMBO_CAP) ? COMBO_CAP : combo_reg + 7'd1;
      end

      max_next = (combo_next > max_reg) ? combo_next : max_reg;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         score_reg <= '0;
         combo_reg <= '0;
         max_reg   <= '0;
         hit_reg   <= 1'b0;
      end else if (sk.active) begin
         score_reg <= score_next;
         combo_reg <= combo_next;
         max_reg   <= max_next;
         hit_reg   <= sum_pos;
      end else begin
         hit_reg   <= 1'b0;
      end
   end

   // ---------------- double-dabble converter ----------------
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

   conv_state_t state_reg, state_next;
   logic [9:0]  bin_reg, bin_next;
   logic [11:0] acc_reg, acc_next;
   logic [11:0] acc_adj;
   logic [9:0]  last_conv_reg, last_conv_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [11:0] bcd_reg, bcd_next;
   logic        busy_reg, busy_next;

   generate
      for (gi = 0; gi < 3; gi++) begin : g_adj
         assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ?
                                     acc_reg[4*gi +: 4] + 4'd3 : acc_reg[4*gi +: 4];
      end
   endgenerate

   always_comb begin
      state_next     = state_reg;
      bin_next       = bin_reg;
      acc_next       = acc_reg;
      last_conv_next = last_conv_reg;
      cnt_next       = cnt_reg;
      bcd_next       = bcd_reg;
      busy_next      = busy_reg;
      case (state_reg)
         IDLE: begin
            // Changes arriving mid-conversion are picked up here afterwards.
            if (score_reg != last_conv_reg) begin
               bin_next       = score_reg;
               last_conv_next = score_reg;
               acc_next       = '0;
               cnt_next       = '0;
               busy_next      = 1'b1;
               state_next     = SHIFT;
            end
         end
         SHIFT: begin
            acc_next = {acc_adj[10:0], bin_reg[9]};
            bin_next = {bin_reg[8:0], 1'b0};
            cnt_next = cnt_reg + 4'd1;
            if (cnt_reg == 4'd9) begin
               state_next = DONE;
            end
         end
         DONE: begin
            bcd_next   = acc_reg;
            busy_next  = 1'b0;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         bin_reg       <= '0;
         acc_reg       <= '0;
         last_conv_reg <= '0;
         cnt_reg       <= '0;
         bcd_reg       <= '0;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         bin_reg       <= bin_next;
         acc_reg       <= acc_next;
         last_conv_reg <= last_conv_next;
         cnt_reg       <= cnt_next;
         bcd_reg       <= bcd_next;
         busy_reg      <= busy_next;
      end
   end

   assign sk.score_bin = score_reg;
   assign sk.score_bcd = bcd_reg;
   assign sk.combo     = combo_reg;
   assign sk.max_combo = max_reg;
   assign sk.hit       = hit_reg;
   assign sk.bcd_busy  = busy_reg;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper
//   Directed stimulus with hand-computed expectations. Each checked cycle
//   pushes its expected outputs into a queue; a monitor pops one entry per
//   clock edge and compares. Expected BCD results are queued separately and
//   popped by a second monitor at every completed conversion.
module tb_score_keeper;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   score_keeper_if #(.NLIGHT(5)) bif ();

   score_keeper #(
      .NLIGHT(5),
      .COMBO_BONUS(10),
      .SCORE_MAX(999)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sk(bif)
   );

   typedef struct {
      string       tag;
      bit          chk_bcd;
      logic [9:0]  score;
      logic [6:0]  combo;
      logic [6:0]  maxc;
      logic        hit;
      logic        busy;
      logic [11:0] bcd;
   } exp_t;

   exp_t        sq[$];
   logic [11:0] bq[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   bit          bcd_en = 1'b1;
   string       tag    = "init";

   localparam logic [3:0] P1 = 4'h1;
   localparam logic [3:0] P2 = 4'h2;
   localparam logic [3:0] M2 = 4'hE;

   task automatic chk(string what, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", what, act, exp);
   endtask

   function automatic logic [19:0] one(int i, logic [3:0] c);
      logic [19:0] v;
      v = '0;
      v[4*i +: 4] = c;
      return v;
   endfunction

   function automatic logic [19:0] all5(logic [3:0] c);
      return {c, c, c, c, c};
   endfunction

   task automatic step(bit rn, bit act, logic [19:0] pt, bit ms, bit chk_on,
                       logic [9:0] s, logic [6:0] c, logic [6:0] m, bit h,
                       bit chk_bcd, bit busy, logic [11:0] bcd);
      exp_t e;
      @(negedge clk);
      rst_n        = rn;
      bif.active   = act;
      bif.pt_bus   = pt;
      bif.miss     = ms;
      if (chk_on) begin
         e.tag = tag; e.chk_bcd = chk_bcd; e.score = s; e.combo = c;
         e.maxc = m; e.hit = h; e.busy = busy; e.bcd = bcd;
         sq.push_back(e);
      end
   endtask

   task automatic go(logic [19:0] pt, bit ms, logic [9:0] s, logic [6:0] c,
                     logic [6:0] m, bit h);
      step(1'b1, 1'b1, pt, ms, 1'b1, s, c, m, h, 1'b0, 1'b0, 12'h000);
   endtask

   task automatic idle(int n, logic [9:0] s, logic [6:0] c, logic [6:0] m);
      repeat (n) go(20'h0, 1'b0, s, c, m, 1'b0);
   endtask

   task automatic free_step(logic [19:0] pt, bit ms);
      step(1'b1, 1'b1, pt, ms, 1'b0, 10'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 12'h000);
   endtask

   task automatic reset_step();
      step(1'b0, 1'b1, all5(P2), 1'b0, 1'b1, 10'd0, 7'd0, 7'd0, 1'b0,
           1'b1, 1'b0, 12'h000);
   endtask

   // Per-cycle monitor
   initial begin : mon_state
      exp_t e;
      forever begin
         @(posedge clk);
         if (sq.size() > 0) begin
            e = sq.pop_front();
            #1;
            $display("[%0t] %s score=%0d combo=%0d max=%0d hit=%0b busy=%0b bcd=%03h",
                     $time, e.tag, bif.score_bin, bif.combo, bif.max_combo,
                     bif.hit, bif.bcd_busy, bif.score_bcd);
            chk({e.tag, ".score"}, 32'(bif.score_bin), 32'(e.score));
            chk({e.tag, ".combo"}, 32'(bif.combo), 32'(e.combo));
            chk({e.tag, ".max_combo"}, 32'(bif.max_combo), 32'(e.maxc));
            chk({e.tag, ".hit"}, 32'(bif.hit), 32'(e.hit));
            if (e.chk_bcd) begin
               chk({e.tag, ".bcd_busy"}, 32'(bif.bcd_busy), 32'(e.busy));
               chk({e.tag, ".score_bcd"}, 32'(bif.score_bcd), 32'(e.bcd));
            end
         end
      end
   end

   // Conversion-completion monitor
   initial begin : mon_bcd
      bit       r;
      bit       busy_prev;
      int       run;
      logic [11:0] eb;
      busy_prev = 1'b0;
      run = 0;
      forever begin
         @(posedge clk);
         r = rst_n;
         #1;
         if (r && busy_prev && !bif.bcd_busy) begin
            chk("bcd_busy_len", 32'(run), 32'd11);
            if (bcd_en) begin
               if (bq.size() == 0) begin
                  chk("bcd_unexpected_done", 32'(bif.score_bcd), 32'hFFFF_FFFF);
               end else begin
                  eb = bq.pop_front();
                  $display("[%0t] conversion done bcd=%03h", $time, bif.score_bcd);
                  chk("bcd_result", 32'(bif.score_bcd), 32'(eb));
               end
            end
         end
         if (!r || !bif.bcd_busy) run = 0;
         else run++;
         busy_prev = bif.bcd_busy;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      bif.active = 1'b0;
      bif.pt_bus = '0;
      bif.miss   = 1'b0;

      tag = "reset";
      reset_step();
      reset_step();

      tag = "single_hit";
      bq.push_back(12'h001);
      step(1, 1, one(3, P1), 0, 1, 10'd1, 7'd1, 7'd1, 1'b1, 1'b1, 1'b0, 12'h000);
      for (int k = 1; k <= 12; k++)
         step(1, 1, 20'h0, 0, 1, 10'd1, 7'd1, 7'd1, 1'b0, 1'b1,
              (k <= 11), (k == 12) ? 12'h001 : 12'h000);

      tag = "penalty";
      bq.push_back(12'h000);
      bq.push_back(12'h010);
      go(one(0, M2), 0, 10'd0, 7'd0, 7'd1, 1'b0);
      go(all5(P2), 0, 10'd10, 7'd1, 7'd1, 1'b1);
      idle(25, 10'd10, 7'd1, 7'd1);

      tag = "bonus";
      reset_step();
      bq.push_back(12'h002);
      bq.push_back(12'h024);
      for (int i = 1; i <= 10; i++)
         go(one(0, P2), 0, 10'(2*i), 7'(i), 7'(i), 1'b1);
      go(one(0, P2), 0, 10'd24, 7'd11, 7'd11, 1'b1);
      idle(16, 10'd24, 7'd11, 7'd11);

      tag = "freeze_miss";
      reset_step();
      bq.push_back(12'h001);
      bq.push_back(12'h006);
      for (int i = 1; i <= 5; i++)
         go(one(0, P1), 0, 10'(i), 7'(i), 7'(i), 1'b1);
      step(1, 0, one(0, P2), 1, 1, 10'd5, 7'd5, 7'd5, 1'b0, 1'b0, 1'b0, 12'h000);
      go(one(0, P1), 1, 10'd6, 7'd0, 7'd5, 1'b1);
      idle(20, 10'd6, 7'd0, 7'd5);

      tag = "saturate";
      reset_step();
      bcd_en = 1'b0;
      for (int i = 1; i <= 54; i++) free_step(all5(P2), 0);
      free_step(all5(P2), 1);
      free_step({4'h0, P1, P2, P2, P2}, 0);
      idle(25, 10'd997, 7'd1, 7'd54);
      bcd_en = 1'b1;
      bq.push_back(12'h999);
      go(one(0, P2), 0, 10'd999, 7'd2, 7'd54, 1'b1);
      go(one(0, P2), 0, 10'd999, 7'd3, 7'd54, 1'b1);
      go(one(0, P2), 0, 10'd999, 7'd4, 7'd54, 1'b1);
      idle(15, 10'd999, 7'd4, 7'd54);

      tag = "race";
      bq.push_back(12'h997);
      bq.push_back(12'h995);
      go(one(0, M2), 0, 10'd997, 7'd0, 7'd54, 1'b0);
      idle(3, 10'd997, 7'd0, 7'd54);
      go(one(0, M2), 0, 10'd995, 7'd0, 7'd54, 1'b0);
      idle(25, 10'd995, 7'd0, 7'd54);

      tag = "reset_mid";
      go(one(0, P1), 0, 10'd996, 7'd1, 7'd54, 1'b1);
      idle(3, 10'd996, 7'd1, 7'd54);
      reset_step();
      repeat (3)
         step(1, 1, 20'h0, 0, 1, 10'd0, 7'd0, 7'd0, 1'b0, 1'b1, 1'b0, 12'h000);

      @(negedge clk);
      @(negedge clk);
      chk("bcd_queue_drained", 32'(bq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
